// File: rtl/pb_field_varint_ser_if.sv
// Field-in / encoded-bytes-out bundle for pb_field_varint_ser.
// master drives the field; slave (the encoder) returns the encoded results.
interface pb_field_varint_ser_if;
  logic        in_valid;
  logic [63:0] value;
  logic [28:0] field_id;
  logic [4:0]  field_type;
  logic        out_valid;
  logic [79:0] varint_out;
  logic [3:0]  varint_len;
  logic [39:0] header_out;
  logic [2:0]  header_len;
  logic        type_err;

  modport master (
    output in_valid, value, field_id, field_type,
    input  out_valid, varint_out, varint_len, header_out, header_len, type_err
  );

  modport slave (
    input  in_valid, value, field_id, field_type,
    output out_valid, varint_out, varint_len, header_out, header_len, type_err
  );
endinterface

// File: rtl/pb_field_varint_ser.sv
// Registered protobuf encoder: value varint plus field key varint, 1-cycle latency.
// Optional macro PB_ZIGZAG_EN applies zigzag to sint32 (17) / sint64 (18) values.
module pb_field_varint_ser (
  input  logic                 clk,
  input  logic                 rst_n,
  pb_field_varint_ser_if.slave bus
);

  logic [63:0] operand;
  logic [69:0] v_ext;
  logic [79:0] v_bytes;
  logic [3:0]  v_len;
  logic [2:0]  wire_type;
  logic        bad_type;
  logic [34:0] k_ext;
  logic [39:0] k_bytes;
  logic [2:0]  k_len;

  always_comb begin
    operand = bus.value;
`ifdef PB_ZIGZAG_EN
    if (bus.field_type == 5'd18)
      operand = (bus.value << 1) ^ {64{bus.value[63]}};
    else if (bus.field_type == 5'd17)
      operand = {32'b0, (bus.value[31:0] << 1) ^ {32{bus.value[31]}}};
`endif
  end

  always_comb begin
    wire_type = 3'd0;
    bad_type  = 1'b0;
    case (bus.field_type)
      5'd3, 5'd4, 5'd5, 5'd8, 5'd13, 5'd14, 5'd17, 5'd18: wire_type = 3'd0;
      5'd1, 5'd6, 5'd16:                                  wire_type = 3'd1;
      5'd9, 5'd11, 5'd12:                                 wire_type = 3'd2;
      5'd10:                                              wire_type = 3'd3;
      5'd2, 5'd7, 5'd15:                                  wire_type = 3'd5;
      default:                                            bad_type  = 1'b1;
    endcase
  end

  // Zero-padding to whole 7-bit groups lets the top byte (bit 63 only) share the loop.
  always_comb begin
    v_ext   = {6'b0, operand};
    v_len   = 4'd1;
    v_bytes = '0;
    for (int unsigned k = 0; k < 10; k++)
      if (v_ext[7*k +: 7] != '0) v_len = 4'(k + 1);
    for (int unsigned k = 0; k < 10; k++)
      if (k < 32'(v_len))
        v_bytes[8*k +: 8] = {(k + 1 < 32'(v_len)), v_ext[7*k +: 7]};
  end

  always_comb begin
    k_ext   = {3'b0, bus.field_id, wire_type};
    k_len   = 3'd1;
    k_bytes = '0;
    for (int unsigned k = 0; k < 5; k++)
      if (k_ext[7*k +: 7] != '0) k_len = 3'(k + 1);
    for (int unsigned k = 0; k < 5; k++)
      if (k < 32'(k_len))
        k_bytes[8*k +: 8] = {(k + 1 < 32'(k_len)), k_ext[7*k +: 7]};
    if (bad_type) begin
      k_bytes = '0;
      k_len   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid  <= 1'b0;
      bus.varint_out <= '0;
      bus.varint_len <= '0;
      bus.header_out <= '0;
      bus.header_len <= '0;
      bus.type_err   <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.varint_out <= v_bytes;
        bus.varint_len <= v_len;
        bus.header_out <= k_bytes;
        bus.header_len <= k_len;
        bus.type_err   <= bad_type;
      end
    end
  end

endmodule

// File: tb/tb_pb_field_varint_ser.sv
// Self-checking bench for pb_field_varint_ser: directed vectors plus random traffic
// against a streaming (divide-by-128) reference encoder.
module tb_pb_field_varint_ser;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  pb_field_varint_ser_if bus ();

  pb_field_varint_ser dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // expected registered outputs
  logic [79:0] e_vout;
  int          e_vlen;
  logic [39:0] e_hout;
  int          e_hlen;
  logic        e_err;

  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void ref_varint(input logic [63:0] v, output logic [79:0] b, output int n);
    logic [63:0] r;
    logic [7:0]  byte_v;
    r = v;
    b = '0;
    n = 0;
    do begin
      byte_v = 8'(r % 128);
      r = r / 128;
      if (r != 0) byte_v = byte_v + 8'd128;
      b = b | (80'(byte_v) << (8 * n));
      n++;
    end while (r != 0);
  endfunction

  function automatic int ref_wire_type(input int t);
    case (t)
      3, 4, 5, 8, 13, 14, 17, 18: return 0;
      1, 6, 16:                   return 1;
      9, 11, 12:                  return 2;
      10:                         return 3;
      2, 7, 15:                   return 5;
      default:                    return -1;
    endcase
  endfunction

  function automatic logic [63:0] ref_operand(input logic [63:0] v, input int t);
`ifdef PB_ZIGZAG_EN
    longint s;
    if (t == 18) begin
      s = longint'(v);
      return (s >= 0) ? 64'(2 * s) : 64'(-2 * s - 1);
    end
    if (t == 17) begin
      s = longint'(int'(v[31:0]));
      return (s >= 0) ? 64'(2 * s) : 64'(-2 * s - 1);
    end
`endif
    return v;
  endfunction

  function automatic void model_load(input logic [63:0] v, input logic [28:0] id, input int t);
    logic [79:0] kb;
    int          kn;
    int          wt;
    ref_varint(ref_operand(v, t), e_vout, e_vlen);
    wt = ref_wire_type(t);
    if (wt < 0) begin
      e_hout = '0;
      e_hlen = 0;
      e_err  = 1'b1;
    end else begin
      ref_varint(64'(id) * 8 + 64'(wt), kb, kn);
      e_hout = kb[39:0];
      e_hlen = kn;
      e_err  = 1'b0;
    end
  endfunction

  task automatic check_outputs(input string tag, input logic exp_valid);
    chk({tag, ".valid"}, 80'(bus.out_valid), 80'(exp_valid));
    chk({tag, ".vout"},  bus.varint_out,     e_vout);
    chk({tag, ".vlen"},  80'(bus.varint_len), 80'(e_vlen));
    chk({tag, ".hout"},  80'(bus.header_out), 80'(e_hout));
    chk({tag, ".hlen"},  80'(bus.header_len), 80'(e_hlen));
    chk({tag, ".err"},   80'(bus.type_err),   80'(e_err));
  endtask

  // present one cycle of input; model follows the registered behaviour
  task automatic cycle(input logic vld, input logic [63:0] v, input logic [28:0] id,
                       input logic [4:0] t, input string tag);
    @(negedge clk);
    bus.in_valid   = vld;
    bus.value      = v;
    bus.field_id   = id;
    bus.field_type = t;
    @(posedge clk);
    #1;
    if (vld) model_load(v, id, int'(t));
    check_outputs(tag, vld);
  endtask

  initial begin
    bus.in_valid   = 1'b0;
    bus.value      = '0;
    bus.field_id   = '0;
    bus.field_type = '0;
    e_vout = '0; e_vlen = 0; e_hout = '0; e_hlen = 0; e_err = 1'b0;

    #12;
    check_outputs("reset", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    cycle(1'b1, 64'd150, 29'd150, 5'd3, "v150_t3");
    chk("v150.const", bus.varint_out, 80'h0196);
    chk("h150t3.const", 80'(bus.header_out), 80'h09B0);
    cycle(1'b1, 64'd0, 29'd150, 5'd1, "v0_t1");
    chk("h150t1.const", 80'(bus.header_out), 80'h09B1);
    chk("v0.const", bus.varint_out, 80'h00);
    cycle(1'b1, '1, 29'd1, 5'd4, "vmax");
    chk("vmax.const", bus.varint_out, 80'h01FF_FFFF_FFFF_FFFF_FFFF);
    chk("vmax.len", 80'(bus.varint_len), 80'd10);
    cycle(1'b1, 64'd127, 29'd1, 5'd5, "v127");
    chk("v127.const", bus.varint_out, 80'h7F);
    cycle(1'b1, 64'd128, 29'h1FFF_FFFF, 5'd9, "v128_hmax");
    chk("v128.const", bus.varint_out, 80'h0180);
    chk("hmax.const", 80'(bus.header_out), 80'h0F_FFFF_FFFA);
    chk("hmax.len", 80'(bus.header_len), 80'd5);
    cycle(1'b1, 64'd5, 29'd7, 5'd0, "t0_err");
    chk("t0.err", 80'(bus.type_err), 80'd1);
    cycle(1'b1, 64'd5, 29'd7, 5'd19, "t19_err");
    cycle(1'b1, 64'd0, 29'd0, 5'd13, "fid0");
    cycle(1'b1, '1, 29'd2, 5'd18, "zz18");
`ifdef PB_ZIGZAG_EN
    chk("zz18.const", bus.varint_out, 80'h01);
    cycle(1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 29'd2, 5'd17, "zz17");
    chk("zz17.const", bus.varint_out, 80'h03);
`else
    chk("nozz18.len", 80'(bus.varint_len), 80'd10);
`endif
    cycle(1'b1, 64'h1234_5678_9ABC_DEF0, 29'd99, 5'd2, "pre_hold");
    cycle(1'b0, '0, '0, '0, "hold1");
    cycle(1'b0, '1, '1, 5'd31, "hold2");

    // asynchronous reset between edges
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    e_vout = '0; e_vlen = 0; e_hout = '0; e_hlen = 0; e_err = 1'b0;
    check_outputs("async_rst", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b0, '0, '0, '0, "post_rst");

    for (int i = 0; i < 400; i++) begin
      logic [63:0] rv;
      logic [28:0] rid;
      logic [4:0]  rt;
      int          sh;
      sh  = $urandom_range(0, 63);
      rv  = {$urandom, $urandom} >> sh;
      if ($urandom_range(0, 3) == 0) rv = ~rv;
      rid = 29'({$urandom} >> $urandom_range(0, 31));
      rt  = 5'($urandom_range(0, 31));
      cycle(($urandom_range(0, 3) != 0), rv, rid, rt, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
